rcpu_sys_uart: RTL and testbench
================================

# rcpu_sys_uart

SYS-port peripheral for the RCPU: it decodes the core's I/O bus (io_read_enable, io_write_enable, io_address, io_write_data) and returns io_read_data. It contains a buffered UART transmitter, a single-byte UART receiver and a status register, so programs can do serial I/O through the SYS instruction. It sits directly downstream of the core's I/O outputs and feeds the data that SYS reads push onto the data stack.

## Interface
- CLKS_PER_BIT, default 104: clock cycles per UART bit; legal values are 4 and above.
- TX_DEPTH, default 16: TX FIFO entries; must be a power of two, 2 or more.
- clk  in  1  system clock, shared with the core.
- reset  in  1  reset; synchronous, active-high.
- io_read_enable  in  1  read strobe, one cycle per SYS read.
- io_write_enable  in  1  write strobe, one cycle per SYS write.
- io_address  in  16  byte address; low two bits are always 0.
- io_write_data  in  16  write data.
- io_read_data  out  16  registered read data.
- uart_tx  out  1  serial output; idles high.
- uart_rx  in  1  serial input; asynchronous to clk.

## Operation
- Bit numbering in this section: bit 0 is the LSB (value 1). Only io_address[3:2] is decoded; higher bits are ignored, so the map aliases.
- 0x0 TX_DATA, write: pushes io_write_data[7:0] into the TX FIFO.
  - If the FIFO is full, the byte is dropped and tx_overflow is set.
  - Reads return 0.
- 0x4 STATUS, read: {11'b0, frame_err, rx_overrun, tx_overflow, rx_valid, tx_full}.
  - A write clears each sticky bit (bits 4:2) where the written value is 1.
  - rx_valid is not writable.
- 0x8 RX_DATA, read: {8'b0, rx_byte}; the read clears rx_valid. Writes are ignored.
- 0xC: reads return 0; writes are ignored.
- TX engine states: IDLE, START, DATA, STOP.
  - IDLE with the FIFO non-empty: pop one byte, go to START.
  - START drives 0, DATA drives 8 bits LSB first, STOP drives 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - STOP then returns to IDLE.
- RX path: uart_rx passes through a 2-flop synchroniser. States: IDLE, START, DATA, STOP.
  - IDLE: a synchronised low moves to START.
  - START: after CLKS_PER_BIT/2 cycles, re-sample. Still low goes to DATA; high is a glitch and returns to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits LSB first.
  - STOP: sample one bit later.
    - If high: load rx_byte and set rx_valid; if rx_valid was already set, also set rx_overrun (the new byte overwrites).
    - If low: discard the byte and set frame_err.
    - Either way, return to IDLE.

## Timing
- Reset values: io_read_data=0 and uart_tx=1. FIFO empty, all flags 0, rx_byte=0, both engines in IDLE.
- Reset mid-frame aborts the frame: uart_tx goes high the cycle after reset is sampled.
- Read latency is 1 cycle: io_read_data is valid the cycle after io_read_enable and holds until the next read.
  - This matches the core's SYS flow: the strobe is issued in the core's writeback state and the data is consumed in its next fetch state.
- Read and write in the same cycle: the read returns the pre-write state, and the write then takes effect.
  - Example: writing STATUS while reading it returns the sticky bits before they are cleared.
- A TX_DATA write while the FIFO is full and the engine pops in the same cycle: the write is accepted, because the pop frees a slot first.
- RX completion and an RX_DATA read in the same cycle: the read returns the old byte; rx_valid stays 1 with the new byte loaded. rx_overrun is set only if rx_valid was 1 and not being cleared that cycle.
- TX first start bit: uart_tx goes low 2 cycles after the write to an empty FIFO (1 cycle to push, 1 cycle to pop).
- Back-to-back TX bytes: the start bit follows the stop bit with at most 1 idle cycle.
- Counters: bit counter is 3 bits and wraps 7 to 0 to exit DATA. Baud counters are clog2(CLKS_PER_BIT) bits and reload on every bit boundary.

## Structure
- Shared package rcpu_pkg holds the address constants (IO_TX_DATA=0x0, IO_STATUS=0x4, IO_RX_DATA=0x8), the STATUS bit indices, and the UART state enum.
- One sub-module, rcpu_sync_fifo (parameters WIDTH, DEPTH), provides the TX FIFO.
  - Ports: push, pop, wdata, rdata, full, empty.
  - rdata is valid combinationally while the FIFO is not empty.
- RX and TX engines stay inline in rcpu_sys_uart.

## Test plan
1. Reset: assert reset for 2 cycles mid-transmission. Required: uart_tx=1, a STATUS read returns 0x0000, a RX_DATA read returns 0x0000.
2. TX frame (CLKS_PER_BIT=4): write 0x0041 to 0x0. Required: uart_tx low for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high for 4 cycles. Start bit begins 2 cycles after the write.
3. FIFO overflow (TX_DEPTH=2): write 4 bytes in consecutive cycles.
   - Required: exactly 3 frames sent (one byte popped into the shifter plus 2 FIFO entries), and STATUS bit 2 reads 1.
   - Then write 0x0004 to STATUS. Required: bit 2 reads 0.
4. RX: drive the frame for 0xA5 on uart_rx.
   - Required: STATUS bit 1 = 1. RX_DATA read returns 0x00A5, and a following STATUS read shows bit 1 = 0.
   - Send a second byte without reading in between. Required: rx_overrun (bit 3) = 1.
5. RX errors:
   - Glitch: a 1-cycle low pulse on uart_rx. Required: no byte, no flags.
   - Framing: a frame with stop bit 0. Required: frame_err (bit 4) = 1, rx_valid = 0.
6. Loopback: connect uart_tx to uart_rx and write 0x0000, 0x00FF, 0x0055. Required: each byte is read back unchanged and no error flags are set.

Source files
------------

// File: rtl/rcpu_pkg.sv
// Shared RCPU definitions: SYS-port I/O map, STATUS bit positions and UART engine states.
package rcpu_pkg;

  localparam logic [15:0] IO_TX_DATA = 16'h0000;
  localparam logic [15:0] IO_STATUS  = 16'h0004;
  localparam logic [15:0] IO_RX_DATA = 16'h0008;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_RX_VALID    = 1;
  localparam int ST_TX_OVERFLOW = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_FRAME_ERR   = 4;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

endpackage

// File: rtl/rcpu_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; a push while full is accepted when a pop frees a slot.
module rcpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rcpu_sys_uart.sv
// SYS-port peripheral: I/O bus decode, FIFO-buffered UART transmitter, single-byte UART receiver, status.
// state | meaning (TX and RX engines): IDLE line idle | START start bit | DATA 8 bits LSB first | STOP stop bit
module rcpu_sys_uart
  import rcpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int          CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]  SEL_TX      = IO_TX_DATA[3:2];
  localparam logic [1:0]  SEL_STATUS  = IO_STATUS[3:2];
  localparam logic [1:0]  SEL_RX      = IO_RX_DATA[3:2];

  logic [1:0] sel;
  logic       wr_tx, wr_status, rd_rx;

  logic       fifo_pop, fifo_full, fifo_empty, fifo_push;
  logic [7:0] fifo_rdata;

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          uart_tx_q, uart_tx_d;

  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_done, rx_ferr;

  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] status_w;
  logic [15:0] io_read_data_q, io_read_data_d;

  logic unused_bits;
  assign unused_bits = ^{io_address[15:4], io_address[1:0], io_write_data[15:8]};

  assign sel       = io_address[3:2];
  assign wr_tx     = io_write_enable && (sel == SEL_TX);
  assign wr_status = io_write_enable && (sel == SEL_STATUS);
  assign rd_rx     = io_read_enable && (sel == SEL_RX);
  assign fifo_push = wr_tx;

  rcpu_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (io_write_data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    uart_tx_d  = 1'b1;
    if (tx_state_q == UART_IDLE) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        tx_shift_d = fifo_rdata;
        tx_cnt_d   = BIT_RELOAD;
        tx_state_d = UART_START;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - CW'(1);
    end else begin
      tx_cnt_d = BIT_RELOAD;
      case (tx_state_q)
        UART_START: begin
          tx_state_d = UART_DATA;
          tx_bit_d   = '0;
        end
        UART_DATA: begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
        end
        default: tx_state_d = UART_IDLE;
      endcase
    end
    // Line level is registered from the next state so uart_tx never glitches.
    case (tx_state_d)
      UART_START: uart_tx_d = 1'b0;
      UART_DATA:  uart_tx_d = tx_shift_d[0];
      default:    uart_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state_q == UART_IDLE) begin
      if (!rx_sync_q) begin
        rx_state_d = UART_START;
        rx_cnt_d   = HALF_RELOAD;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - CW'(1);
    end else begin
      rx_cnt_d = BIT_RELOAD;
      case (rx_state_q)
        UART_START: begin
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? UART_IDLE : UART_DATA;
        end
        UART_DATA: begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = UART_STOP;
        end
        default: begin
          rx_done    = rx_sync_q;
          rx_ferr    = !rx_sync_q;
          rx_state_d = UART_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status_w                 = '0;
    status_w[ST_TX_FULL]     = fifo_full;
    status_w[ST_RX_VALID]    = rx_valid_q;
    status_w[ST_TX_OVERFLOW] = tx_overflow_q;
    status_w[ST_RX_OVERRUN]  = rx_overrun_q;
    status_w[ST_FRAME_ERR]   = frame_err_q;

    rx_byte_d  = rx_done ? rx_shift_q : rx_byte_q;
    rx_valid_d = rx_done ? 1'b1 : (rd_rx ? 1'b0 : rx_valid_q);

    // Set events win over a simultaneous write-one-to-clear.
    tx_overflow_d = (tx_overflow_q && !(wr_status && io_write_data[ST_TX_OVERFLOW]))
                    || (wr_tx && fifo_full && !fifo_pop);
    rx_overrun_d  = (rx_overrun_q && !(wr_status && io_write_data[ST_RX_OVERRUN]))
                    || (rx_done && rx_valid_q && !rd_rx);
    frame_err_d   = (frame_err_q && !(wr_status && io_write_data[ST_FRAME_ERR])) || rx_ferr;

    io_read_data_d = io_read_data_q;
    if (io_read_enable) begin
      io_read_data_d = '0;
      if (sel == SEL_STATUS)  io_read_data_d = status_w;
      else if (sel == SEL_RX) io_read_data_d = {8'h00, rx_byte_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q     <= UART_IDLE;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_shift_q     <= '0;
      uart_tx_q      <= 1'b1;
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_state_q     <= UART_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_byte_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_overrun_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      io_read_data_q <= '0;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_shift_q     <= tx_shift_d;
      uart_tx_q      <= uart_tx_d;
      rx_meta_q      <= rx_meta_d;
      rx_sync_q      <= rx_sync_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_overrun_q   <= rx_overrun_d;
      frame_err_q    <= frame_err_d;
      io_read_data_q <= io_read_data_d;
    end
  end

  assign io_read_data = io_read_data_q;
  assign uart_tx      = uart_tx_q;

endmodule

// File: tb/tb_rcpu_sys_uart.sv
// Scoreboard bench for rcpu_sys_uart: queued expected reads and TX frames, checked by independent monitors.
module tb_rcpu_sys_uart;
  import rcpu_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = '0;
  logic [15:0] io_write_data = '0;
  logic [15:0] io_read_data;
  logic        uart_tx, uart_rx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        tx_mon_en = 1'b0;
  logic        rd_pend = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] rd_exp_q[$];
  int          rd_tag_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [15:0] rd_e;
  int          rd_t;
  logic [7:0]  mon_b;
  logic        mon_stop;
  logic [9:0]  frame41;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  rcpu_sys_uart #(.CLKS_PER_BIT(CPB), .TX_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_read_enable  (io_read_enable),
    .io_write_enable (io_write_enable),
    .io_address      (io_address),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .uart_tx         (uart_tx),
    .uart_rx         (uart_rx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_write_enable = 1'b1; io_address = a; io_write_data = d;
    @(negedge clk);
    io_write_enable = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, input logic [15:0] e, input int tag);
    @(negedge clk);
    io_read_enable = 1'b1; io_address = a;
    rd_exp_q.push_back(e); rd_tag_q.push_back(tag);
    @(negedge clk);
    io_read_enable = 1'b0;
  endtask

  task automatic io_rw(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e, input int tag);
    @(negedge clk);
    io_read_enable = 1'b1; io_write_enable = 1'b1; io_address = a; io_write_data = d;
    rd_exp_q.push_back(e); rd_tag_q.push_back(tag);
    @(negedge clk);
    io_read_enable = 1'b0; io_write_enable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_drv = 1'b1;
  endtask

  // Read monitor: data is due the cycle after each strobe.
  always @(posedge clk) rd_pend <= io_read_enable;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %h want none", io_read_data);
      end else begin
        rd_e = rd_exp_q.pop_front();
        rd_t = rd_tag_q.pop_front();
        check($sformatf("read_tag%0d", rd_t), {16'h0, io_read_data}, {16'h0, rd_e});
      end
    end
  end

  // Serial monitor: decodes every frame on uart_tx and compares with the expected TX queue.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_mid", {31'h0, uart_tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        mon_stop = uart_tx;
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got %h want none", mon_b);
        end else begin
          check("tx_byte", {24'h0, mon_b}, {24'h0, tx_exp_q.pop_front()});
          check("tx_stop", {31'h0, mon_stop}, 32'h1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Power-on reset values
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_read_data", {16'h0, io_read_data}, 32'h0);
    reset = 1'b0;

    // Reset in the middle of a frame
    io_write(IO_TX_DATA, 16'h0055);
    repeat (11) @(negedge clk);
    check("tx_midframe_low", {31'h0, uart_tx}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("tx_high_after_reset", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    tx_mon_en = 1'b1;
    io_read(IO_STATUS, 16'h0000, 10);
    io_read(IO_RX_DATA, 16'h0000, 11);
    repeat (50) @(negedge clk);

    // Exact frame timing for 0x41
    tx_exp_q.push_back(8'h41);
    frame41 = {1'b1, 8'h41, 1'b0};
    io_write(IO_TX_DATA, 16'h0041);
    check("tx_idle_after_push", {31'h0, uart_tx}, 32'h1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check($sformatf("tx_bit_k%0d", k), {31'h0, uart_tx}, {31'h0, frame41[k / CPB]});
    end
    repeat (10) @(negedge clk);

    // FIFO overflow: four back-to-back writes, the fourth is dropped
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io_write_enable = 1'b1; io_address = IO_TX_DATA; io_write_data = 16'((i + 1) * 17);
      if (i < 3) tx_exp_q.push_back(8'((i + 1) * 17));
    end
    @(negedge clk);
    io_write_enable = 1'b0;
    io_read(IO_STATUS, 16'h0005, 30);
    repeat (140) @(negedge clk);
    io_read(IO_STATUS, 16'h0004, 31);
    io_write(IO_STATUS, 16'h0004);
    io_read(IO_STATUS, 16'h0000, 32);
    io_read(IO_TX_DATA, 16'h0000, 33);
    io_read(16'h000C, 16'h0000, 34);

    // RX single byte, then overrun
    send_rx(8'hA5, 1'b1);
    repeat (6) @(negedge clk);
    io_read(16'h0014, 16'h0002, 40);
    io_read(IO_RX_DATA, 16'h00A5, 41);
    io_read(IO_STATUS, 16'h0000, 42);
    send_rx(8'h3C, 1'b1);
    repeat (6) @(negedge clk);
    send_rx(8'h5A, 1'b1);
    repeat (6) @(negedge clk);
    io_read(IO_STATUS, 16'h000A, 43);
    io_read(IO_RX_DATA, 16'h005A, 44);
    io_rw(IO_STATUS, 16'h0008, 16'h0008, 45);
    io_read(IO_STATUS, 16'h0000, 46);

    // RX glitch and framing error
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    io_read(IO_STATUS, 16'h0000, 50);
    send_rx(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    io_rw(IO_STATUS, 16'h0010, 16'h0010, 51);
    io_read(IO_STATUS, 16'h0000, 52);

    // Loopback
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h00 : ((i == 1) ? 8'hFF : 8'h55);
      tx_exp_q.push_back(b);
      io_write(IO_TX_DATA, {8'h00, b});
      repeat (50) @(negedge clk);
      io_read(IO_RX_DATA, {8'h00, b}, 60 + i);
      io_read(IO_STATUS, 16'h0000, 70 + i);
    end

    repeat (10) @(negedge clk);
    check("rd_queue_drained", rd_exp_q.size(), 32'h0);
    check("tx_frames_drained", tx_exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
